i2s_tdm_transceiver: RTL
========================

# i2s_tdm_transceiver

Parametrised full-duplex I2S/TDM master transceiver that replaces the separate fixed-stereo sender and receiver pair in the audio IO layer. Generates one shared `sclk`/`ws` pair from `mclk` and serialises `n_channels` slots per frame out on `sd_tx` while deserialising the same slots from `sd_rx`. Exchanges whole frames with the effects datapath through single-cycle `tx_ready`/`rx_valid` strobes.

## Interface
- `mclk_sclk_ratio`, 4: mclk periods per sclk period; even, ≥2.
- `sclk_ws_ratio`, 64: sclk periods per frame.
- `d_width`, 24: sample width, signed two's complement.
- `n_channels`, 2: slots per frame; even, ≥2. Slot width `slot_w = sclk_ws_ratio/n_channels` must be ≥ `d_width+1`; violations are an elaboration error.

Ports:
- `mclk` in 1: master clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `sclk` out 1: serial bit clock.
- `ws` out 1: word select.
- `sd_tx` out 1: serial data out.
- `sd_rx` in 1: serial data in.
- `tx_data` in `n_channels*d_width`: frame to send; slot k is in bits `[k*d_width +: d_width]`.
- `tx_ready` out 1: one-mclk pulse when `tx_data` is latched.
- `rx_data` out `n_channels*d_width`: last complete received frame, same packing.
- `rx_valid` out 1: one-mclk pulse when `rx_data` updates.
- `loopback` in 1: present only with `I2S_LOOPBACK_EN`.

## Operation
- Registers: `mclk_cnt` (0..`mclk_sclk_ratio/2-1`), `bit_cnt` (0..`sclk_ws_ratio-1`), tx shift buffer, rx shift buffer, `rx_data`.
- `sclk` toggles on the cycle `mclk_cnt` reaches its terminal value, then `mclk_cnt` wraps to 0.
- A rise event is a cycle where `sclk` goes 0→1. A fall event is a cycle where `sclk` goes 1→0.
- `bit_cnt` increments on every fall event and wraps from `sclk_ws_ratio-1` to 0. A wrap is a frame boundary.
- Slot decode: `slot = bit_cnt / slot_w`, `pos = bit_cnt % slot_w`.
- `ws` is registered: 0 while `slot < n_channels/2`, 1 otherwise. It changes on fall events only. With `n_channels=2` this is standard I2S (ws low = left).
- Tx, one-bit I2S delay:
  - For `pos` in 1..`d_width`, `sd_tx` drives bit `d_width-pos` of the latched slot, MSB first.
  - For `pos=0` and `pos>d_width`, `sd_tx=0`.
  - `sd_tx` is updated on fall events only.
- Rx:
  - On rise events with `pos` in 1..`d_width`, `sd_rx` is shifted into slot `slot`, MSB first.
  - Other bit positions are ignored.
- Frame boundary behaviour:
  - tx shift buffer loads `tx_data` and `tx_ready` pulses.
  - `rx_data` loads the completed rx buffer and `rx_valid` pulses.
  - Both strobes occur in the same mclk cycle.
- Reset release: the first mclk cycle with `reset=0` is treated as a tx load. `tx_data` is latched and `tx_ready` pulses. No `rx_valid` pulse occurs until the first wrap.
- The upstream source must hold `tx_data` stable in the cycle where `tx_ready` is high. Values presented at any other time are ignored.
- Reset asserted mid-frame: on the next edge all counters, buffers and outputs return to their reset values. The partial rx frame is discarded and no strobes are emitted.

## Timing
- Reset values: `sclk=0`, `ws=0`, `sd_tx=0`, `tx_ready=0`, `rx_valid=0`, `rx_data=0`, all counters 0.
- sclk period is `mclk_sclk_ratio` mclk cycles. The first rise event occurs `mclk_sclk_ratio/2` cycles after reset release.
- Frame length is `mclk_sclk_ratio*sclk_ws_ratio` mclk cycles (256 at defaults).
- Tx latency: the MSB of slot 0 appears on `sd_tx` at the fall event where `bit_cnt` becomes 1, one sclk after the `ws` edge.
- Rx latency:
  - The last sampled bit is at `bit_cnt=(n_channels-1)*slot_w+d_width`.
  - It is visible in `rx_data` in the cycle after the next wrap, which is the cycle where `rx_valid` is high.
- The constraint `slot_w ≥ d_width+1` guarantees the final LSB is sampled before the wrap.

## Configuration
- `I2S_LOOPBACK_EN` defined:
  - Adds the `loopback` input.
  - While `loopback=1`, the rx path samples the internal registered `sd_tx` instead of `sd_rx`.
  - `sd_tx` still drives the pin.
- `I2S_LOOPBACK_EN` undefined: the port and the mux are absent, and rx always samples `sd_rx`.

## Test plan
- Reset: hold `reset` for 10 cycles mid-frame. Required: all outputs are 0 during reset, and `tx_ready` pulses exactly once in the first cycle after release.
- Clocking at defaults:
  - `sclk` period is 4 cycles.
  - `ws` period is 256 cycles with 50% duty.
  - `ws` changes only on fall events.
  - `rx_valid` pulses every 256 cycles.
- Tx serialisation: `tx_data={24'h800001, 24'hA5A5A5}` (right, left). Required: the left slot shows `A5A5A5` MSB-first starting 1 sclk after `ws` falls, the right slot shows `800001`, and all other bit positions are 0.
- Rx capture: the bench drives an I2S model sending left `24'h7FFFFF` and right `24'h000001`. Required: the `rx_data` packing matches and `rx_valid` is asserted in the cycle after the wrap.
- TDM: with `n_channels=8` and `sclk_ws_ratio=256`, send slots `k*24'h010101` for k=0..7. Required: `ws` is low for slots 0-3 and every slot round-trips through a bench `sd_rx` echo of `sd_tx`.
- Loopback (`I2S_LOOPBACK_EN`): `loopback=1` with `sd_rx` tied to 0 and `tx_data` incrementing per frame. Required: `rx_data` equals the `tx_data` latched one frame earlier.

Source files
------------

// File: rtl/i2s_tdm_transceiver_if.sv
// Frame-level bus between the I2S/TDM transceiver and the effects datapath.
// The datapath side uses the master modport, the transceiver uses slave.
interface i2s_tdm_transceiver_if #(
  parameter int n_channels = 2,
  parameter int d_width    = 24
) ();
  logic [n_channels*d_width-1:0] tx_data;
  logic                          tx_ready;
  logic [n_channels*d_width-1:0] rx_data;
  logic                          rx_valid;

  modport master (output tx_data, input tx_ready, input rx_data, input rx_valid);
  modport slave  (input tx_data, output tx_ready, output rx_data, output rx_valid);
endinterface

// File: rtl/i2s_tdm_transceiver.sv
// Full-duplex I2S/TDM master: derives sclk/ws from mclk and exchanges whole frames.
// Optional feature macro: I2S_LOOPBACK_EN adds a loopback input routing sd_tx into the rx path.
module i2s_tdm_transceiver #(
  parameter int mclk_sclk_ratio = 4,
  parameter int sclk_ws_ratio   = 64,
  parameter int d_width         = 24,
  parameter int n_channels      = 2
) (
  input  logic mclk,
  input  logic reset,
  output logic sclk,
  output logic ws,
  output logic sd_tx,
  input  logic sd_rx,
`ifdef I2S_LOOPBACK_EN
  input  logic loopback,
`endif
  i2s_tdm_transceiver_if.slave frame
);

  localparam int half   = mclk_sclk_ratio / 2;
  localparam int slot_w = sclk_ws_ratio / n_channels;
  localparam int fw     = n_channels * d_width;
  localparam int mw     = (half > 1) ? $clog2(half) : 1;
  localparam int bw     = $clog2(sclk_ws_ratio);
  localparam int iw     = $clog2(fw);

  if (mclk_sclk_ratio < 2 || (mclk_sclk_ratio % 2) != 0) begin : g_bad_ratio
    $error("mclk_sclk_ratio must be even and at least 2");
  end
  if (n_channels < 2 || (n_channels % 2) != 0) begin : g_bad_channels
    $error("n_channels must be even and at least 2");
  end
  if ((sclk_ws_ratio % n_channels) != 0 || slot_w < d_width + 1) begin : g_bad_slot
    $error("slot width must divide the frame and hold d_width+1 bits");
  end

  logic [mw-1:0] mclk_cnt;
  logic [bw-1:0] bit_cnt;
  logic [bw-1:0] bit_nxt;
  logic [fw-1:0] tx_buf;
  logic [fw-1:0] rx_buf;
  logic [fw-1:0] rx_data_r;
  logic          sclk_r;
  logic          ws_r;
  logic          sd_tx_r;
  logic          tx_ready_r;
  logic          rx_valid_r;
  logic          load_pending;
  logic          toggle;
  logic          rise;
  logic          fall;
  logic          wrap;
  logic          tx_bit;
  logic          rx_bit;
  logic [iw-1:0] tx_idx;
  int            cur_slot;
  int            cur_pos;
  int            nxt_slot;
  int            nxt_pos;

  always_comb begin
    toggle   = (mclk_cnt == mw'(half - 1));
    rise     = toggle & ~sclk_r;
    fall     = toggle & sclk_r;
    wrap     = fall && (bit_cnt == bw'(sclk_ws_ratio - 1));
    bit_nxt  = (bit_cnt == bw'(sclk_ws_ratio - 1)) ? '0 : bit_cnt + bw'(1);
    cur_slot = int'(bit_cnt) / slot_w;
    cur_pos  = int'(bit_cnt) % slot_w;
    nxt_slot = int'(bit_nxt) / slot_w;
    nxt_pos  = int'(bit_nxt) % slot_w;
    tx_idx   = '0;
    tx_bit   = 1'b0;
    // sd_tx is computed for the bit position that the coming fall event enters
    if (nxt_pos >= 1 && nxt_pos <= d_width) begin
      tx_idx = iw'(nxt_slot * d_width + d_width - nxt_pos);
      tx_bit = tx_buf[tx_idx];
    end
    rx_bit = sd_rx;
`ifdef I2S_LOOPBACK_EN
    if (loopback) rx_bit = sd_tx_r;
`endif
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      mclk_cnt     <= '0;
      sclk_r       <= 1'b0;
      bit_cnt      <= '0;
      ws_r         <= 1'b0;
      sd_tx_r      <= 1'b0;
      tx_buf       <= '0;
      rx_buf       <= '0;
      rx_data_r    <= '0;
      tx_ready_r   <= 1'b0;
      rx_valid_r   <= 1'b0;
      load_pending <= 1'b1;
    end else begin
      // tx_data is captured at the end of the cycle in which tx_ready is high
      load_pending <= 1'b0;
      tx_ready_r   <= load_pending | wrap;
      rx_valid_r   <= wrap;
      if (tx_ready_r) tx_buf <= frame.tx_data;
      if (wrap) rx_data_r <= rx_buf;

      if (toggle) begin
        mclk_cnt <= '0;
        sclk_r   <= ~sclk_r;
      end else begin
        mclk_cnt <= mclk_cnt + mw'(1);
      end

      if (fall) begin
        bit_cnt <= bit_nxt;
        ws_r    <= (nxt_slot >= n_channels / 2);
        sd_tx_r <= tx_bit;
      end

      for (int k = 0; k < n_channels; k++) begin
        if (rise && cur_pos >= 1 && cur_pos <= d_width && cur_slot == k)
          rx_buf[k*d_width +: d_width] <= {rx_buf[k*d_width +: d_width-1], rx_bit};
      end
    end
  end

  assign sclk           = sclk_r;
  assign ws             = ws_r;
  assign sd_tx          = sd_tx_r;
  assign frame.tx_ready = tx_ready_r;
  assign frame.rx_data  = rx_data_r;
  assign frame.rx_valid = rx_valid_r;

endmodule
